// File: rtl/proc_instr_sequencer.sv
// Issue side of the DIN/Run/Done processor handshake. A writable program store
// is stepped one word per Run/Done exchange, and a hung core is caught by a wait timeout.
module proc_instr_sequencer #(
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned TIMEOUT = 8
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Wr_en,
    input  logic [ADDR_W-1:0] Wr_addr,
    input  logic [15:0]       Wr_data,
    input  logic              Start,
    input  logic [ADDR_W:0]   Length,
    input  logic              Done,
    output logic [15:0]       DIN,
    output logic              Run,
    output logic              Busy,
    output logic              Finished,
    output logic              Timeout_err,
    output logic [ADDR_W-1:0] PC
);

    localparam int unsigned WORD_W = 16;
    localparam int unsigned LEN_W  = ADDR_W + 1;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned DEPTH  = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_FIN
    } state_t;

    state_t             state;
    logic [WORD_W-1:0]  mem [DEPTH];
    logic [CNT_W-1:0]   wait_cnt;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   len_clamped;
    logic [ADDR_W-1:0]  last_pc;
    logic [CNT_W-1:0]   cnt_inc;

    // Runs longer than the store are cut to its depth so PC never wraps.
    assign len_clamped = (Length > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : Length;
    assign last_pc     = ADDR_W'(len_q - LEN_W'(1));
    assign cnt_inc     = wait_cnt + CNT_W'(1);

    // Program store: uninitialised, frozen while a program is executing.
    always_ff @(posedge Clock) begin
        if (Wr_en && !Busy) begin
            mem[Wr_addr] <= Wr_data;
        end
    end

    assign DIN = mem[PC];

    // Sequencer FSM; Run, Busy and Finished are registered alongside the state.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state       <= S_IDLE;
            PC          <= '0;
            Run         <= 1'b0;
            Busy        <= 1'b0;
            Finished    <= 1'b0;
            Timeout_err <= 1'b0;
            wait_cnt    <= '0;
            len_q       <= '0;
        end else begin
            Run      <= 1'b0;
            Finished <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        Timeout_err <= 1'b0;
                        if (Length == '0) begin
                            Finished <= 1'b1;
                        end else begin
                            len_q <= len_clamped;
                            PC    <= '0;
                            Run   <= 1'b1;
                            Busy  <= 1'b1;
                            state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    // A Done seen here still belongs to the previous word.
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    wait_cnt <= cnt_inc;
                    if (Done) begin
                        if (PC == last_pc) begin
                            Finished <= 1'b1;
                            Busy     <= 1'b0;
                            state    <= S_FIN;
                        end else begin
                            PC    <= PC + ADDR_W'(1);
                            Run   <= 1'b1;
                            state <= S_ISSUE;
                        end
                    end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
                        Timeout_err <= 1'b1;
                        Busy        <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    Busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
